// File: rtl/spi_word_sequencer_pkg.sv
// spi_word_sequencer shared package.
// State encoding and default parameter values.
package spi_word_sequencer_pkg;

    localparam int DEF_WORDWIDTH     = 8;
    localparam int DEF_RX_DEPTH_LOG2 = 2;
    localparam int DEF_CS_GAP_CLKS   = 2;
    localparam int DEF_TIMEOUT_CLKS  = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENABLE  = 3'd1,
        TRIGGER = 3'd2,
        WAIT    = 3'd3,
        HOLD    = 3'd4,
        GAP     = 3'd5
    } state_t;

endpackage

// File: rtl/spi_word_sequencer_rx_fifo.sv
// RX word FIFO for spi_word_sequencer.
// Wrapping pointers plus a count with one extra bit for full/empty.
module spi_word_sequencer_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (DEPTH_LOG2+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (DEPTH_LOG2+1)'(1);
            end
        end
    end

endmodule

// File: rtl/spi_word_sequencer.sv
// Word sequencer driving an SPI master's control ports.
// Optional watchdog: define SPI_WORD_SEQUENCER_WATCHDOG_EN.
module spi_word_sequencer
    import spi_word_sequencer_pkg::*;
#(
    parameter int WORDWIDTH     = DEF_WORDWIDTH,
    parameter int RX_DEPTH_LOG2 = DEF_RX_DEPTH_LOG2,
    parameter int CS_GAP_CLKS   = DEF_CS_GAP_CLKS,
    parameter int TIMEOUT_CLKS  = DEF_TIMEOUT_CLKS
) (
    input  logic                 system_clk,
    input  logic                 rst,
    input  logic [WORDWIDTH-1:0] tx_data,
    input  logic                 tx_last,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORDWIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 m_xfer_enable,
    input  logic                 m_xfer_idle,
    output logic                 m_xfer_word_trigger,
    input  logic                 m_xfer_word_completed,
    output logic [WORDWIDTH-1:0] m_data_tx,
    input  logic [WORDWIDTH-1:0] m_data_rx
);

    localparam int GW = $clog2(CS_GAP_CLKS + 1);
    localparam logic [GW-1:0] GAP_END = GW'(CS_GAP_CLKS - 1);

    if (CS_GAP_CLKS < 1) begin : g_bad_gap
        $error("CS_GAP_CLKS must be at least 1");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 1");
    end

    state_t          state;
    state_t          state_next;
    logic            ready_en;
    logic            last_q;
    logic            accept;
    logic            push;
    logic            fifo_full;
    logic            timeout;
    logic [GW-1:0]   gap_cnt;

    assign tx_ready = ready_en & ~fifo_full
                    & ((state == IDLE) | (state == HOLD));
    assign accept   = tx_valid & tx_ready;
    assign push     = (state == WAIT) & m_xfer_word_completed;
    assign busy     = (state != IDLE);

    assign m_xfer_enable = (state == ENABLE) | (state == TRIGGER)
                         | (state == WAIT)   | (state == HOLD);
    assign m_xfer_word_trigger = (state == TRIGGER);

`ifdef SPI_WORD_SEQUENCER_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_run;
    logic          wd_hit;
    logic          progress;

    assign wd_run   = (state == ENABLE) | (state == WAIT);
    assign wd_hit   = (wd_cnt == TW'(TIMEOUT_CLKS - 1));
    assign progress = ((state == ENABLE) & m_xfer_idle)
                    | ((state == WAIT) & m_xfer_word_completed);
    assign timeout  = wd_run & wd_hit & ~progress;

    // Watchdog: counts clocks spent in ENABLE/WAIT, cleared on entry.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (!wd_run || (state_next != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign timeout_err = timeout;

    // State register, tx word capture, GAP length counter.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            last_q    <= 1'b0;
            m_data_tx <= '0;
            gap_cnt   <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (accept) begin
                m_data_tx <= tx_data;
                last_q    <= tx_last;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Next-state logic; completion wins over a coincident timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = ENABLE;
            end
            ENABLE: begin
                if (m_xfer_idle) state_next = TRIGGER;
                else if (timeout) state_next = GAP;
            end
            TRIGGER: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (m_xfer_word_completed) begin
                    state_next = last_q ? GAP : HOLD;
                end else if (timeout) begin
                    state_next = GAP;
                end
            end
            HOLD: begin
                if (accept) state_next = TRIGGER;
            end
            GAP: begin
                if (gap_cnt == GAP_END) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    spi_word_sequencer_rx_fifo #(
        .WIDTH      (WORDWIDTH),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (system_clk),
        .rst       (rst),
        .push      (push),
        .push_data (m_data_rx),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .valid     (rx_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer with a behavioural SPI master/slave.
// Watchdog checks run when SPI_WORD_SEQUENCER_WATCHDOG_EN is defined.
module tb_spi_word_sequencer;

    localparam int WW        = 4;
    localparam int CLK_DIV   = 4;
    localparam int XFER_CLKS = 2 * CLK_DIV * WW;
    localparam int GAP       = 2;

    logic          system_clk = 1'b0;
    logic          rst = 1'b1;
    logic [WW-1:0] tx_data = '0;
    logic          tx_last = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [WW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic          m_xfer_enable;
    logic          m_xfer_idle;
    logic          m_xfer_word_trigger;
    logic          m_xfer_word_completed;
    logic [WW-1:0] m_data_tx;
    logic [WW-1:0] m_data_rx = '0;

    spi_word_sequencer #(
        .WORDWIDTH     (WW),
        .RX_DEPTH_LOG2 (2),
        .CS_GAP_CLKS   (GAP),
        .TIMEOUT_CLKS  (16)
    ) dut (
        .system_clk            (system_clk),
        .rst                   (rst),
        .tx_data               (tx_data),
        .tx_last               (tx_last),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .rx_data               (rx_data),
        .rx_valid              (rx_valid),
        .rx_ready              (rx_ready),
        .busy                  (busy),
        .timeout_err           (timeout_err),
        .m_xfer_enable         (m_xfer_enable),
        .m_xfer_idle           (m_xfer_idle),
        .m_xfer_word_trigger   (m_xfer_word_trigger),
        .m_xfer_word_completed (m_xfer_word_completed),
        .m_data_tx             (m_data_tx),
        .m_data_rx             (m_data_rx)
    );

    always #5 system_clk = ~system_clk;

    // Behavioural master + slave: idle one clock after enable,
    // a word takes XFER_CLKS clocks, slave replies from slave_q.
    logic          en_d = 1'b0;
    logic          xbusy = 1'b0;
    logic          comp = 1'b0;
    logic          hold_done = 1'b0;
    int            xcnt = 0;
    logic [WW-1:0] slave_q[$];
    logic [WW-1:0] got_q[$];
    logic [WW-1:0] rx_log[$];

    assign m_xfer_idle           = en_d & ~xbusy & ~comp;
    assign m_xfer_word_completed = comp;

    always @(posedge system_clk) begin
        en_d <= m_xfer_enable;
        comp <= 1'b0;
        if (rst || !m_xfer_enable) begin
            xbusy <= 1'b0;
            xcnt  <= 0;
        end else if (m_xfer_word_trigger && !xbusy) begin
            xbusy <= 1'b1;
            xcnt  <= XFER_CLKS - 1;
            got_q.push_back(m_data_tx);
        end else if (xbusy && !hold_done) begin
            if (xcnt == 0) begin
                xbusy <= 1'b0;
                comp  <= 1'b1;
                if (slave_q.size() > 0) m_data_rx <= slave_q.pop_front();
                else m_data_rx <= '0;
            end else begin
                xcnt <= xcnt - 1;
            end
        end
    end

    // Event monitors sampled on the falling edge.
    int   trig_cnt = 0;
    int   cs_falls = 0;
    int   gap_cyc = 0;
    int   tout_cnt = 0;
    int   ready_hi = 0;
    logic en_prev = 1'b0;

    always @(negedge system_clk) begin
        if (m_xfer_word_trigger) trig_cnt++;
        if (en_prev && !m_xfer_enable) cs_falls++;
        if (busy && !m_xfer_enable) gap_cyc++;
        if (timeout_err) tout_cnt++;
        if (tx_ready) ready_hi++;
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        en_prev = m_xfer_enable;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [WW-1:0] d, input logic l);
        int n;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge system_clk);
            n++;
        end
        check("send_ready", {31'd0, tx_ready}, 1);
        @(negedge system_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rx_valid && n < 400) begin
            @(negedge system_clk);
            n++;
        end
        check("rx_valid_wait", {31'd0, rx_valid}, 1);
    endtask

    task automatic wait_rx(input int cnt);
        int n;
        n = 0;
        while (rx_log.size() < cnt && n < 600) begin
            @(negedge system_clk);
            n++;
        end
        check("rx_count", rx_log.size(), cnt);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge system_clk);
            n++;
        end
        repeat (2) @(negedge system_clk);
        check("idle", {31'd0, busy}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge system_clk);
        tx_valid = 1'b0;
        rst = 1'b1;
        @(negedge system_clk);
        rst = 1'b0;
        @(negedge system_clk);
        slave_q.delete();
        got_q.delete();
        rx_log.delete();
    endtask

    task automatic check_q(input string tag, input logic [WW-1:0] q[$],
                           input logic [WW-1:0] exp[$]);
        check({tag, "_len"}, q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q.size(); i++) begin
            check(tag, {28'd0, q[i]}, {28'd0, exp[i]});
        end
    endtask

    int t0;
    int c0;
    int g0;
    int r0;
    int n;

    initial begin
        // Reset state
        #23;
        check("rst_ctl", {26'd0, m_xfer_enable, m_xfer_word_trigger,
              tx_ready, busy, rx_valid, timeout_err}, 0);
        check("rst_data", {24'd0, m_data_tx, rx_data}, 0);
        @(negedge system_clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {31'd0, tx_ready}, 0);
        @(negedge system_clk);
        check("ready_after_edge", {31'd0, tx_ready}, 1);

        // Single word
        slave_q = '{4'b1010};
        t0 = trig_cnt; c0 = cs_falls; g0 = gap_cyc;
        send(4'b0110, 1'b1);
        wait_valid();
        check("t1_rx", {28'd0, rx_data}, 4'b1010);
        wait_idle();
        check("t1_trig", trig_cnt - t0, 1);
        check("t1_cs_falls", cs_falls - c0, 1);
        check("t1_gap", gap_cyc - g0, GAP);
        check_q("t1_mosi", got_q, '{4'b0110});
        rx_ready = 1'b1;
        @(negedge system_clk);
        rx_ready = 1'b0;
        check("t1_popped", {31'd0, rx_valid}, 0);

        // Three words, continuous CS
        got_q.delete(); rx_log.delete();
        slave_q = '{4'h3, 4'h9, 4'hE};
        rx_ready = 1'b1;
        t0 = trig_cnt; c0 = cs_falls; g0 = gap_cyc;
        send(4'b1010, 1'b0);
        send(4'b0101, 1'b0);
        send(4'b1100, 1'b1);
        wait_rx(3);
        wait_idle();
        check("t2_trig", trig_cnt - t0, 3);
        check("t2_cs_falls", cs_falls - c0, 1);
        check("t2_gap", gap_cyc - g0, GAP);
        check_q("t2_rx", rx_log, '{4'h3, 4'h9, 4'hE});
        check_q("t2_mosi", got_q, '{4'b1010, 4'b0101, 4'b1100});

        // Back-pressure: FIFO fills after four words
        got_q.delete(); rx_log.delete();
        slave_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h7};
        rx_ready = 1'b0;
        t0 = trig_cnt;
        send(4'h0, 1'b0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        tx_data = 4'h4; tx_last = 1'b0; tx_valid = 1'b1;
        repeat (XFER_CLKS + 8) @(negedge system_clk);
        r0 = ready_hi;
        repeat (60) @(negedge system_clk);
        check("t3_ready_low", ready_hi - r0, 0);
        check("t3_trig", trig_cnt - t0, 4);
        check("t3_full_valid", {31'd0, rx_valid}, 1);
        rx_ready = 1'b1;
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        wait_rx(6);
        check("t3_trig_all", trig_cnt - t0, 6);
        check_q("t3_rx", rx_log, '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h7});
        check_q("t3_mosi", got_q, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5});

        // Reset during WAIT of word 2
        pulse_reset();
        rx_ready = 1'b0;
        slave_q = '{4'h6, 4'hB};
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        repeat (5) @(negedge system_clk);
        check("t4_pre_valid", {31'd0, rx_valid}, 1);
        check("t4_pre_cs", {31'd0, m_xfer_enable}, 1);
        rst = 1'b1;
        #1;
        check("t4_cs_drop", {31'd0, m_xfer_enable}, 0);
        check("t4_fifo_empty", {31'd0, rx_valid}, 0);
        check("t4_busy", {31'd0, busy}, 0);
        @(negedge system_clk);
        rst = 1'b0;
        repeat (XFER_CLKS + 10) @(negedge system_clk);
        check("t4_no_push", {31'd0, rx_valid}, 0);
        slave_q = '{4'hD};
        send(4'h7, 1'b1);
        wait_valid();
        check("t4_rx_after", {28'd0, rx_data}, 4'hD);
        wait_idle();
        rx_ready = 1'b1;
        @(negedge system_clk);
        rx_ready = 1'b0;

        // Simultaneous push and pop at count 1
        slave_q = '{4'h5, 4'hC};
        send(4'h1, 1'b0);
        wait_valid();
        check("t5_first", {28'd0, rx_data}, 4'h5);
        send(4'h2, 1'b1);
        n = 0;
        while (!m_xfer_word_completed && n < 400) begin
            @(negedge system_clk);
            n++;
        end
        check("t5_completed", {31'd0, m_xfer_word_completed}, 1);
        rx_ready = 1'b1;
        @(negedge system_clk);
        rx_ready = 1'b0;
        check("t5_valid_kept", {31'd0, rx_valid}, 1);
        check("t5_new_word", {28'd0, rx_data}, 4'hC);
        rx_ready = 1'b1;
        @(negedge system_clk);
        rx_ready = 1'b0;
        check("t5_count_was_1", {31'd0, rx_valid}, 0);
        wait_idle();

`ifdef SPI_WORD_SEQUENCER_WATCHDOG_EN
        // Watchdog expiry in WAIT
        hold_done = 1'b1;
        t0 = tout_cnt;
        send(4'h3, 1'b1);
        n = 0;
        while (!m_xfer_word_trigger && n < 50) begin
            @(negedge system_clk);
            n++;
        end
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge system_clk);
            n++;
        end
        check("t6_timeout_at", n, 16);
        @(negedge system_clk);
        check("t6_cs_drop", {31'd0, m_xfer_enable}, 0);
        check("t6_pulse_1clk", tout_cnt - t0, 1);
        wait_idle();
        check("t6_no_rx", {31'd0, rx_valid}, 0);
        hold_done = 1'b0;
`else
        check("no_timeout", tout_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
